// File: rtl/enc_pkg.sv
// enc_pkg: shared state encoding, default geometry and bit-index helpers
// for the theta engine and its line datapath.
package enc_pkg;

  localparam int ENC_LANES_DEF = 64;
  localparam int ENC_COLS_DEF  = 5;
  localparam int ENC_ROWS_DEF  = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PARITY = 2'd1,
    ST_APPLY  = 2'd2,
    ST_DONE   = 2'd3
  } enc_state_e;

  // Bit position of column x, row y inside one line.
  function automatic int bit_idx(input int x, input int y, input int cols);
    return x + cols * y;
  endfunction

  // Column to the left, wrapping column 0 onto the last column.
  function automatic int col_dec(input int x, input int cols);
    return (x == 0) ? cols - 1 : x - 1;
  endfunction

  // Column to the right, wrapping the last column onto column 0.
  function automatic int col_inc(input int x, input int cols);
    return (x == cols - 1) ? 0 : x + 1;
  endfunction

endpackage

// File: rtl/enc_theta_line.sv
// enc_theta_line: combinational transform of one line. Every bit is
// flipped by the parity of the column to its left in the same line and
// the parity of the column to its right in the previous line.
module enc_theta_line
  import enc_pkg::*;
#(
  parameter int COLS = ENC_COLS_DEF,
  parameter int ROWS = ENC_ROWS_DEF,
  localparam int W   = ROWS * COLS
) (
  input  logic [W-1:0]    line_i,
  input  logic [COLS-1:0] par_cur_i,
  input  logic [COLS-1:0] par_prev_i,
  output logic [W-1:0]    line_o
);

  // Index arithmetic is resolved at elaboration, so each output bit is a
  // fixed three-input XOR.
  for (genvar gy = 0; gy < ROWS; gy++) begin : g_row
    for (genvar gx = 0; gx < COLS; gx++) begin : g_col
      localparam int B  = bit_idx(gx, gy, COLS);
      localparam int XM = col_dec(gx, COLS);
      localparam int XP = col_inc(gx, COLS);
      assign line_o[B] = line_i[B] ^ par_cur_i[XM] ^ par_prev_i[XP];
    end
  end

endmodule

// File: rtl/enc_theta_engine.sv
// enc_theta_engine: sweeps an external line memory in two passes. The
// parity pass collects column parities of every line, the apply pass
// rewrites each line in place through enc_theta_line.
// Optional feature macro: ENC_MULTI_ROUND_EN adds num_rounds and runs
// several parity/apply rounds back-to-back.
//
// state     | meaning
// ----------+------------------------------------------------------
// ST_IDLE   | after reset, waiting for start
// ST_PARITY | reading line rd_addr, storing its column parities
// ST_APPLY  | reading line rd_addr, writing the transformed line back
// ST_DONE   | run finished, done held until the next start
module enc_theta_engine
  import enc_pkg::*;
#(
  parameter int LANES = ENC_LANES_DEF,
  parameter int COLS  = ENC_COLS_DEF,
  parameter int ROWS  = ENC_ROWS_DEF,
  localparam int W    = ROWS * COLS,
  localparam int AW   = $clog2(LANES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
`ifdef ENC_MULTI_ROUND_EN
  input  logic [7:0]    num_rounds,
`endif
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] rd_addr,
  input  logic [W-1:0]  rd_data,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [W-1:0]  wr_data
);

  localparam logic [AW-1:0] LAST = AW'(LANES - 1);

  enc_state_e      state_q;
  logic [AW-1:0]   rd_addr_q;
  logic            busy_q;
  logic            done_q;
  logic            wr_en_q;
  logic [COLS-1:0] par_q [LANES];
`ifdef ENC_MULTI_ROUND_EN
  logic [7:0]      rounds_left_q;
`endif

  logic [COLS-1:0] col_par;
  logic [COLS-1:0] par_cur;
  logic [COLS-1:0] par_prev;
  logic [AW-1:0]   z_prev;

  // Column parities of the line currently on rd_data.
  for (genvar gx = 0; gx < COLS; gx++) begin : g_par
    logic [ROWS-1:0] col_bits;
    for (genvar gy = 0; gy < ROWS; gy++) begin : g_bit
      assign col_bits[gy] = rd_data[bit_idx(gx, gy, COLS)];
    end
    assign col_par[gx] = ^col_bits;
  end

  // LANES is a power of two, so the address subtract wraps line 0 onto
  // the last line for free.
  assign z_prev   = rd_addr_q - AW'(1);
  assign par_cur  = par_q[rd_addr_q];
  assign par_prev = par_q[z_prev];

  enc_theta_line #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_line (
    .line_i     (rd_data),
    .par_cur_i  (par_cur),
    .par_prev_i (par_prev),
    .line_o     (wr_data)
  );

  // Sequencer: address walk, parity capture and registered status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      rd_addr_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      wr_en_q       <= 1'b0;
      par_q         <= '{default: '0};
`ifdef ENC_MULTI_ROUND_EN
      rounds_left_q <= '0;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q   <= ST_PARITY;
            rd_addr_q <= '0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            wr_en_q   <= 1'b0;
`ifdef ENC_MULTI_ROUND_EN
            // Zero rounds behaves like one; the counter holds rounds
            // still owed after the current one.
            rounds_left_q <= (num_rounds == 8'd0) ? 8'd0 : num_rounds - 8'd1;
`endif
          end
        end
        ST_PARITY: begin
          par_q[rd_addr_q] <= col_par;
          if (rd_addr_q == LAST) begin
            state_q   <= ST_APPLY;
            rd_addr_q <= '0;
            wr_en_q   <= 1'b1;
          end else begin
            rd_addr_q <= rd_addr_q + AW'(1);
          end
        end
        ST_APPLY: begin
          if (rd_addr_q == LAST) begin
            rd_addr_q <= '0;
            wr_en_q   <= 1'b0;
`ifdef ENC_MULTI_ROUND_EN
            if (rounds_left_q != 8'd0) begin
              state_q       <= ST_PARITY;
              rounds_left_q <= rounds_left_q - 8'd1;
            end else begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
`else
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
`endif
          end else begin
            rd_addr_q <= rd_addr_q + AW'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          wr_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign wr_en   = wr_en_q;
  assign rd_addr = rd_addr_q;
  assign wr_addr = rd_addr_q;

endmodule

// File: tb/tb_enc_theta_engine.sv
// tb_enc_theta_engine: directed bench with a behavioural line memory.
module tb_enc_theta_engine;

  logic        clk;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic [5:0]  rd_addr;
  logic [24:0] rd_data;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [24:0] wr_data;
`ifdef ENC_MULTI_ROUND_EN
  logic [7:0]  num_rounds;
`endif

  logic [24:0] mem [64];
  logic [24:0] gm  [64];
  logic        ld_req;
  logic [5:0]  ld_addr;
  logic [24:0] ld_data;
  int          wr_cnt;
  int          nz_cnt;
  int          rise_cnt;
  bit          done_prev;
  int          n_vec;
  int          n_err;

  enc_theta_engine dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
`ifdef ENC_MULTI_ROUND_EN
    .num_rounds (num_rounds),
`endif
    .busy       (busy),
    .done       (done),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rd_data = mem[rd_addr];

  // memory: bench load has priority, otherwise DUT writes
  always @(posedge clk) begin
    if (ld_req) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
      mem[ld_addr] <= ld_data;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
      wr_cnt <= wr_cnt + 1;
      if (wr_data != '0) nz_cnt <= nz_cnt + 1;
    end
  end

  // done rising-edge counter
  always @(negedge clk) begin
    done_prev <= done;
    if (done && !done_prev) rise_cnt <= rise_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load(input int z, input logic [24:0] v);
    @(negedge clk);
    ld_req  = 1'b1;
    ld_addr = z[5:0];
    ld_data = v;
    @(negedge clk);
    ld_req  = 1'b0;
  endtask

  // start one run, optionally pulse start again pulse_at cycles in,
  // return edges from acceptance to first done cycle
  task automatic do_run(input int pulse_at, output int n);
    n = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (!done && n < 2000) begin
      start = (n == pulse_at);
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
  endtask

  function automatic int nz_lines(input int a, input int b);
    int c;
    c = 0;
    for (int i = 0; i < 64; i++)
      if (i != a && i != b && mem[i] != '0) c++;
    return c;
  endfunction

  function automatic int bad_lines();
    int c;
    c = 0;
    for (int i = 0; i < 64; i++)
      if (mem[i] !== gm[i]) c++;
    return c;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 64; i++) gm[i] = '0;
  endtask

  // reference theta round on gm
  task automatic model_round();
    logic [4:0]  c  [64];
    logic [24:0] nx [64];
    for (int z = 0; z < 64; z++)
      for (int x = 0; x < 5; x++) begin
        c[z][x] = 1'b0;
        for (int y = 0; y < 5; y++) c[z][x] = c[z][x] ^ gm[z][x + 5*y];
      end
    for (int z = 0; z < 64; z++)
      for (int x = 0; x < 5; x++)
        for (int y = 0; y < 5; y++)
          nx[z][x + 5*y] = gm[z][x + 5*y] ^ c[z][(x + 4) % 5] ^ c[(z + 63) % 64][(x + 1) % 5];
    for (int z = 0; z < 64; z++) gm[z] = nx[z];
  endtask

  initial begin
    int n;
    int w0;
    int nz0;
    int r0;
    rst = 1'b0; start = 1'b0;
    ld_req = 1'b0; ld_addr = '0; ld_data = '0;
`ifdef ENC_MULTI_ROUND_EN
    num_rounds = 8'd1;
`endif
    repeat (2) @(posedge clk); #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wren", wr_en, 0);
    chk("rst_rdaddr", rd_addr, 0);
    chk("rst_wraddr", wr_addr, 0);

    @(negedge clk); rst = 1'b1;
    repeat (4) @(posedge clk); #1;
    chk("idle_busy", busy, 0);
    chk("idle_rdaddr", rd_addr, 0);
    chk("idle_wren", wr_en, 0);

    // all-zero memory
    load(0, 25'h0);
    w0 = wr_cnt; nz0 = nz_cnt; r0 = rise_cnt;
    do_run(-1, n);
    chk("zero_cycles", n, 128);
    chk("zero_writes", wr_cnt - w0, 64);
    chk("zero_nonzero", nz_cnt - nz0, 0);
    repeat (3) @(posedge clk); #1;
    chk("zero_done_hold", done, 1);
    chk("zero_busy", busy, 0);
    chk("zero_rises", rise_cnt - r0, 1);

    // single bit in line 0
    load(0, 25'h1);
    do_run(-1, n);
    chk("l0_cycles", n, 128);
    chk("l0_line0", mem[0], 25'h0210843);
    chk("l0_line1", mem[1], 25'h1084210);
    chk("l0_others", nz_lines(0, 1), 0);

    // start held in DONE relaunches on the next edge; content is theta twice
    model_clear(); gm[0] = 25'h1; model_round(); model_round();
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1;
    chk("held_busy", busy, 1);
    chk("held_done", done, 0);
    start = 1'b0;
    n = 0;
    while (!done && n < 2000) begin @(posedge clk); #1; n++; end
    chk("held_cycles", n, 128);
    chk("held_lines", bad_lines(), 0);

    // wrap case: single bit in line 63
    load(63, 25'h1);
    do_run(-1, n);
    chk("l63_cycles", n, 128);
    chk("l63_line0", mem[0], 25'h1084210);
    chk("l63_line63", mem[63], 25'h0210843);
    chk("l63_others", nz_lines(0, 63), 0);

    // start pulsed during PARITY is ignored
    load(0, 25'h1);
    w0 = wr_cnt; r0 = rise_cnt;
    do_run(10, n);
    repeat (3) @(posedge clk); #1;
    chk("pulse_cycles", n, 128);
    chk("pulse_writes", wr_cnt - w0, 64);
    chk("pulse_rises", rise_cnt - r0, 1);
    chk("pulse_line0", mem[0], 25'h0210843);

    // reset in APPLY at line 30
    load(5, 25'h1ABCDEF);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!(wr_en && wr_addr == 6'd30) && n < 500) begin @(posedge clk); #1; n++; end
    chk("mid_reach30", wr_addr, 30);
    rst = 1'b0;
    #1;
    chk("mid_wren", wr_en, 0);
    chk("mid_busy", busy, 0);
    chk("mid_rdaddr", rd_addr, 0);
    w0 = wr_cnt;
    repeat (3) @(posedge clk); #1;
    chk("mid_nowrite", wr_cnt - w0, 0);
    @(negedge clk); rst = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk("mid_idle", busy, 0);
    load(0, 25'h1);
    do_run(-1, n);
    chk("restart_cycles", n, 128);
    chk("restart_line0", mem[0], 25'h0210843);
    chk("restart_line1", mem[1], 25'h1084210);
    chk("restart_others", nz_lines(0, 1), 0);

`ifdef ENC_MULTI_ROUND_EN
    // two rounds back-to-back
    load(0, 25'h1);
    model_clear(); gm[0] = 25'h1; model_round(); model_round();
    num_rounds = 8'd2;
    do_run(-1, n);
    chk("mr2_cycles", n, 256);
    chk("mr2_lines", bad_lines(), 0);
    // zero rounds behaves as one
    load(0, 25'h1);
    num_rounds = 8'd0;
    do_run(-1, n);
    chk("mr0_cycles", n, 128);
    chk("mr0_line0", mem[0], 25'h0210843);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/enc_theta_engine.md
ENC_THETA_ENGINE -- requirements
Module: enc_theta_engine

Interface
REQ-001 SHALL have parameter LANES, default 64, meaning number of lines (slices) in the state memory; power of two, 4..256.
REQ-002 SHALL have parameter COLS, default 5, meaning columns per line; COLS >= 3.
REQ-003 SHALL have parameter ROWS, default 5, meaning rows per line; line width W = ROWS*COLS, default 25.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, meaning reset; asynchronous, active-low.
REQ-006 SHALL have port start, input, 1, meaning a run request, sampled only in IDLE or DONE.
REQ-007 SHALL have port busy, output, 1, meaning high in PARITY and APPLY.
REQ-008 SHALL have port done, output, 1, meaning high in DONE until the next accepted start.
REQ-009 SHALL have port rd_addr, output, log2(LANES), meaning the registered read address.
REQ-010 SHALL have port rd_data, input, W, meaning mem[rd_addr], valid combinationally in the same cycle.
REQ-011 SHALL have port wr_en, output, 1, meaning write strobe for the current line.
REQ-012 SHALL have port wr_addr, output, log2(LANES), meaning write address, equal to rd_addr in APPLY.
REQ-013 SHALL have port wr_data, output, W, meaning the transformed line.

Function
REQ-014 SHALL use bit index b = x + COLS*y within a line, with x in 0..COLS-1 and y in 0..ROWS-1; line index z = slice.
REQ-015 SHALL implement FSM states IDLE, PARITY, APPLY and DONE; start in IDLE or DONE -> PARITY, with rd_addr=0 and done cleared.
REQ-016 In PARITY, SHALL read one line per cycle at rd_addr 0..LANES-1 and store C[z][x] = XOR over y of line z bit(x,y) in a LANES x COLS register array; after z=LANES-1 -> APPLY, rd_addr=0.
REQ-017 In APPLY, SHALL assert wr_en every cycle with wr_data bit(x,y) = in bit(x,y) ^ C[z][(x-1) mod COLS] ^ C[(z-1) mod LANES][(x+1) mod COLS].
REQ-018 SHALL wrap both indices: x-1 of column 0 is COLS-1, x+1 of COLS-1 is 0, and z-1 of line 0 is LANES-1.
REQ-019 After the APPLY write of line LANES-1, SHALL enter DONE, or re-enter PARITY if rounds remain (REQ-026).
REQ-020 A single round SHALL take exactly 2*LANES cycles from the cycle start is accepted to the first DONE cycle.
REQ-021 SHALL ignore start while busy; start held high in DONE SHALL begin a new run on the next edge.
REQ-022 SHALL drive wr_en=0 in every state other than APPLY; wr_data is don't-care when wr_en=0.

Reset
REQ-023 When rst is low, SHALL go to IDLE immediately: busy=0, done=0, wr_en=0, rd_addr=0, wr_addr=0, round counter=0 and C cleared, including when reset arrives mid-run.
REQ-024 After reset release, SHALL take no action until start is sampled high.

Configuration
REQ-025 SHALL support the macro ENC_MULTI_ROUND_EN.
REQ-026 With ENC_MULTI_ROUND_EN defined, SHALL add input num_rounds[7:0], latched at start, where 0 is treated as 1; the block runs that many PARITY/APPLY rounds back-to-back, each round reading the previous round's writes.
REQ-027 Without ENC_MULTI_ROUND_EN, there SHALL be no num_rounds port and exactly one round is performed.

Structure
REQ-028 Package enc_pkg SHALL hold the state enum, default LANES/ROWS/COLS constants and the bit-index helper functions.
REQ-029 Sub-module enc_theta_line SHALL compute one transformed line from a line plus two COLS-bit parity vectors, and SHALL be purely combinational.

Verification
REQ-030 All-zero memory, one round -> 64 writes of 0; done rises exactly 128 cycles after start is accepted.
REQ-031 Only line 0 = 0x0000001 -> line 0 = 0x0210843, line 1 = 0x1084210, all other lines 0.
REQ-032 Wrap case: only line 63 = 0x0000001 -> line 0 = 0x1084210, line 63 = 0x0210843, all other lines 0.
REQ-033 rst pulsed low mid-APPLY at line 30 -> wr_en=0 and busy=0 in the same cycle, no further writes, and a restart completes normally.
REQ-034 start pulsed during PARITY -> ignored, with exactly one done rise and 64 writes.
REQ-035 With ENC_MULTI_ROUND_EN, num_rounds=2 and line 0 = 0x0000001 -> 256 cycles to done, and the memory matches the golden model applied twice.
